// File: rtl/lsu_mem_master.sv
// Data-memory initiator for the core's load/store unit.
// Every access first probes the RAM with a read (CHECK). Stores and AMOs only
// write in a separate WRITE cycle, so an address that faults never gets written.
module lsu_mem_master #(
    parameter int XLEN            = 64,
    parameter bit CHECK_AMO_ALIGN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_kind,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [4:0]      req_amo_op,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic [1:0]      rsp_exception,
    output logic            mem_enable,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_data,
    output logic [1:0]      mem_memo,
    output logic [7:0]      mem_mask,
    input  logic [XLEN-1:0] mem_resp,
    input  logic [1:0]      mem_exception
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CHECK = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic [1:0] KIND_LOAD  = 2'b00;
    localparam logic [1:0] KIND_STORE = 2'b01;
    localparam logic [1:0] KIND_AMO   = 2'b10;
    localparam logic [1:0] KIND_ILL   = 2'b11;

    localparam logic [1:0] EXC_MISALIGN = 2'b01;
    localparam logic [1:0] EXC_ILLEGAL  = 2'b11;

    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    logic [1:0]      state;
    logic [1:0]      kind_q;
    logic [1:0]      size_q;
    logic            unsigned_q;
    logic [4:0]      amo_op_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] old_q;
    logic [XLEN-1:0] rsp_data_q;
    logic [1:0]      rsp_exc_q;
    logic [XLEN-1:0] alu_out;
    logic [7:0]      size_mask;
    logic            amo_misaligned;

    // Sign- or zero-extend the low 1/2/4 bytes; doubles pass through.
    function automatic logic [XLEN-1:0] extend(
        input logic [XLEN-1:0] d,
        input logic [1:0]      size,
        input logic            zext
    );
        logic [XLEN-1:0] r;
        case (size)
            2'd0:    r = {{(XLEN-8){d[7] & ~zext}}, d[7:0]};
            2'd1:    r = {{(XLEN-16){d[15] & ~zext}}, d[15:0]};
            2'd2:    r = {{(XLEN-32){d[31] & ~zext}}, d[31:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    // Word operands are sign-extended to full width so one pair of 64-bit
    // comparators serves both sizes: sign extension preserves both the signed
    // and the unsigned ordering of 32-bit values. Word results keep [31:0] only.
    function automatic logic [XLEN-1:0] amo_alu(
        input logic [4:0]      op,
        input logic            is_word,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic [XLEN-1:0] aa;
        logic [XLEN-1:0] bb;
        logic [XLEN-1:0] r;
        logic            lt_s;
        logic            lt_u;
        if (is_word) begin
            aa = {{(XLEN-32){a[31]}}, a[31:0]};
            bb = {{(XLEN-32){b[31]}}, b[31:0]};
        end else begin
            aa = a;
            bb = b;
        end
        lt_s = $signed(aa) < $signed(bb);
        lt_u = aa < bb;
        case (op)
            5'b00001: r = bb;
            5'b00000: r = aa + bb;
            5'b00100: r = aa ^ bb;
            5'b01100: r = aa & bb;
            5'b01000: r = aa | bb;
            5'b10000: r = lt_s ? aa : bb;
            5'b10100: r = lt_s ? bb : aa;
            5'b11000: r = lt_u ? aa : bb;
            5'b11100: r = lt_u ? bb : aa;
            default:  r = aa;
        endcase
        if (is_word) begin
            r = {{(XLEN-32){1'b0}}, r[31:0]};
        end
        return r;
    endfunction

    assign alu_out   = amo_alu(amo_op_q, size_q == SIZE_W, old_q, wdata_q);
    assign req_ready = (state == IDLE) && !reset;
    assign rsp_valid = (state == RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_exception = rsp_exc_q;
    assign mem_addr  = addr_q;

    // Natural-alignment test for an incoming AMO (only W/D reach this check).
    always_comb begin
        amo_misaligned = 1'b0;
        if (req_size == SIZE_W) begin
            amo_misaligned = (req_addr[1:0] != 2'b00);
        end else if (req_size == SIZE_D) begin
            amo_misaligned = (req_addr[2:0] != 3'b000);
        end
    end

    // Byte-lane write mask for the latched access size.
    always_comb begin
        case (size_q)
            2'd0:    size_mask = 8'h01;
            SIZE_H:  size_mask = 8'h03;
            SIZE_W:  size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    end

    // RAM control: probe read in CHECK, write in WRITE, all quiet under reset.
    always_comb begin
        mem_enable = 1'b0;
        mem_memo   = '0;
        mem_mask   = '0;
        mem_data   = '0;
        if (!reset) begin
            case (state)
                CHECK: begin
                    mem_enable = 1'b1;
                end
                WRITE: begin
                    mem_enable = 1'b1;
                    mem_memo   = 2'b01;
                    mem_mask   = size_mask;
                    mem_data   = (kind_q == KIND_AMO) ? alu_out : wdata_q;
                end
                default: begin
                end
            endcase
        end
    end

    // Request FSM: latch, screen, probe, optionally write, then hold the response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            kind_q     <= '0;
            size_q     <= '0;
            unsigned_q <= 1'b0;
            amo_op_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            old_q      <= '0;
            rsp_data_q <= '0;
            rsp_exc_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        kind_q     <= req_kind;
                        size_q     <= req_size;
                        unsigned_q <= req_unsigned;
                        amo_op_q   <= req_amo_op;
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        rsp_data_q <= '0;
                        rsp_exc_q  <= '0;
                        if ((req_kind == KIND_ILL) ||
                            ((req_kind == KIND_AMO) && (req_size < SIZE_W))) begin
                            rsp_exc_q <= EXC_ILLEGAL;
                            state     <= RESP;
                        end else if (CHECK_AMO_ALIGN && (req_kind == KIND_AMO) &&
                                     amo_misaligned) begin
                            rsp_exc_q <= EXC_MISALIGN;
                            state     <= RESP;
                        end else begin
                            state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    old_q <= mem_resp;
                    if (mem_exception != 2'b00) begin
                        rsp_exc_q  <= mem_exception;
                        rsp_data_q <= '0;
                        state      <= RESP;
                    end else if (kind_q == KIND_LOAD) begin
                        rsp_data_q <= extend(mem_resp, size_q, unsigned_q);
                        state      <= RESP;
                    end else begin
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    if (kind_q == KIND_STORE) begin
                        rsp_data_q <= '0;
                    end else begin
                        rsp_data_q <= extend(old_q, size_q, 1'b0);
                    end
                    state <= RESP;
                end
                default: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Initiator side of the core's data-memory port. Sits between the core's execute stage and the byte-addressed RAM.
- Accepts load, store and atomic (AMO) requests on a valid/ready interface.
- Drives the RAM's addr/data/memo/mask/enable lines and returns sized, extended read data plus an exception code.
- Stores and AMOs are gated on a probe cycle. The RAM writes regardless of its own exception output, so this block must ensure a faulting address never receives a write.

Parameters:
- XLEN, 64, data and address width; only 64 is supported.
- CHECK_AMO_ALIGN, 1, when 1, an AMO whose address is not naturally aligned raises exception 2'b01 without touching memory.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  core request valid
- req_ready  out  1  block can accept a request
- req_kind  in  2  00 load, 01 store, 10 AMO, 11 reserved (treated as illegal)
- req_size  in  2  0 byte, 1 half, 2 word, 3 double
- req_unsigned  in  1  zero-extend load result
- req_amo_op  in  5  RISC-V funct5: 00001 swap, 00000 add, 00100 xor, 01100 and, 01000 or, 10000 min, 10100 max, 11000 minu, 11100 maxu
- req_addr  in  64  byte address
- req_wdata  in  64  store data / AMO operand, right-justified
- rsp_valid  out  1  response valid
- rsp_ready  in  1  core accepts response
- rsp_data  out  64  extended load / AMO old value; 0 for stores and exceptions
- rsp_exception  out  2  00 none, 01 misaligned, 10 access fault, 11 illegal request
- mem_enable  out  1  RAM enable
- mem_addr  out  64  RAM address
- mem_data  out  64  RAM write data, right-justified
- mem_memo  out  2  bit0 = write; bit1 always 0
- mem_mask  out  8  byte-lane mask relative to mem_addr
- mem_resp  in  64  RAM read data (combinational from mem_addr)
- mem_exception  in  2  RAM exception (combinational from mem_addr)

Behaviour:
- FSM states: IDLE, CHECK, WRITE, RESP.
- req_ready = (state == IDLE) && !reset.
- Reset: state IDLE, rsp_valid 0, rsp_data 0, rsp_exception 0, all request registers 0.
- mem_enable, mem_memo, mem_mask and mem_data are combinational from state and are forced to 0 whenever reset is high. A reset during WRITE therefore never produces a write. Reset mid-operation abandons the request with no response.
- IDLE, on req_valid:
  - Latch the request.
  - req_kind == 11, or AMO with size B/H: go to RESP with exception 11.
  - AMO not naturally aligned (W: addr[1:0] != 0; D: addr[2:0] != 0) with CHECK_AMO_ALIGN = 1: go to RESP with exception 01.
  - Otherwise go to CHECK.
- CHECK:
  - Drive mem_addr = latched addr, mem_enable = 1, mem_memo = 00, mem_mask = 0.
  - Capture mem_resp into old_q and mem_exception into exc_q.
  - exc_q != 0: go to RESP with that exception; no write is ever issued.
  - Load: go to RESP; rsp_data = extend(old_q).
  - Store or AMO: go to WRITE.
- WRITE:
  - mem_enable = 1, mem_memo = 01, mem_addr = latched addr.
  - mem_mask by size: B 0x01, H 0x03, W 0x0F, D 0xFF.
  - mem_data: store = req_wdata; AMO = alu(old_q, wdata).
  - AMO rsp_data = extend(old_q); store rsp_data = 0. Then go to RESP.
- Extension:
  - B/H/W loads sign-extend from bit 7/15/31 unless req_unsigned (then zero-extend); D loads pass through.
  - AMO.W response is always sign-extended from bit 31.
- AMO.W arithmetic operates on bits [31:0]:
  - min/max compare 32-bit signed; minu/maxu compare unsigned; add wraps at 32 bits.
  - Written value occupies bits [31:0].
- AMO.D arithmetic is full 64-bit; add wraps modulo 2^64.
- RESP: rsp_valid = 1, with rsp_data and rsp_exception held stable until rsp_ready. On rsp_valid && rsp_ready, go to IDLE; a new request is accepted no earlier than the following cycle.
- Latency from the accept edge:
  - Load: rsp_valid after 2 edges (CHECK, then RESP).
  - Store/AMO: rsp_valid after 3 edges.
  - Early exception: rsp_valid after 1 edge.
- Unaligned loads/stores that are not AMOs are passed through unchanged; the RAM handles arbitrary byte offsets.

Test Plan:
- Memory 0x100 = 0x80. Load B signed at 0x100 -> rsp_data 0xFFFF_FFFF_FFFF_FF80, exc 00, 2 cycles. Same load unsigned -> 0x0000_0000_0000_0080.
- Store H 0xBEEF at 0x203 (unaligned), then load D at 0x200 -> bytes 0x203/0x204 = EF/BE, other bytes unchanged; WRITE cycle shows mem_mask 0x03, mem_memo 01.
- Store D at 0x1_0000_0000 (RAM returns exc 10) -> rsp_exception 10, mem_memo never 01 during the transaction, memory unchanged.
- AMO.W add at 0x300 (holds 0x7FFF_FFFF), operand 1 -> rsp_data 0x0000_0000_7FFF_FFFF, memory [31:0] = 0x8000_0000. AMO.W min with operand 0xFFFF_FFFF -> rsp_data 0xFFFF_FFFF_8000_0000, memory [31:0] = 0x8000_0000.
- AMO.D swap at 0x304 -> exc 01 after 1 cycle, mem_enable stays 0 throughout. AMO size B -> exc 11.
- Reset asserted in the WRITE cycle of a store -> no memory change, state IDLE, rsp_valid 0. Hold rsp_ready low 5 cycles in RESP -> rsp_valid and data held stable, req_ready 0.
